conv_acc_out_unpack: RTL
========================

# conv_acc_out_unpack

Receive-side counterpart of the accelerator's packed result stream. Accepts 32-bit AXI-Stream words, each carrying two requantized int16 channel results (low half first), and re-emits them as a 16-bit per-channel AXI-Stream tagged with a channel index. Tracks pixel/row framing against the configured output geometry and stops after a configured number of rows. Sits between the accelerator's m_axis port and the output feature-map writer.

## Interface
- NUM_PE, 32, channels per output pixel; must be even; words per pixel WPP = NUM_PE/2
- CNT_WIDTH, 16, width of pixel/row counters and geometry inputs
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  32  [15:0] = even channel, [31:16] = odd channel
- s_axis_tvalid  in  1  input word valid
- s_axis_tlast  in  1  end of output row
- s_axis_tready  out  1  input word accepted when high with tvalid
- m_axis_tdata  out  16  one channel result
- m_axis_tchan  out  $clog2(NUM_PE)  channel index of current beat
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  last channel of last pixel of a row
- m_axis_tready  in  1  downstream ready
- out_pixels  in  CNT_WIDTH  pixels per row; sampled on start
- out_rows  in  CNT_WIDTH  rows per job; sampled on start
- start  in  1  single-cycle job start pulse
- busy  out  1  high in RUN
- row_done  out  1  one-cycle pulse on each output tlast handshake
- job_done  out  1  one-cycle pulse when final row completes
- err_early_last  out  1  sticky; tlast before expected position
- err_missing_last  out  1  sticky; expected row end without tlast

## Operation
- States IDLE, RUN. IDLE: s_axis_tready=0. start with out_pixels!=0 and out_rows!=0 -> RUN; latch geometry; clear counters, error flags. start with either zero, or start while RUN: ignored.
- Holding register: hold_data[31:0], hold_v, hold_half (0=low, 1=high), hold_last.
- s_axis_tready = (state==RUN) && (!hold_v || (hold_half && m_axis_tready)).
- Input accept: hold_data<=tdata, hold_v<=1, hold_half<=0, hold_last<=tlast.
- m_axis_tvalid=hold_v; tdata = hold_half ? hold_data[31:16] : hold_data[15:0]; tchan = {word_idx, hold_half}; tlast = hold_v && hold_half && hold_last.
- Output handshake on low half: hold_half<=1. On high half: hold_v<=0 unless a new word is accepted same cycle (new word wins).
- word_idx (0..WPP-1) increments on each accepted input word, wraps at WPP-1.
- row_cnt counts tlast output handshakes; row_done pulses each; when row_cnt reaches out_rows: job_done pulse, -> IDLE same edge, row_cnt cleared. Words accepted while no job is running are impossible (tready=0).
- Framing check (macro-gated): pix_cnt increments when word_idx wraps. Expected end = (word_idx==WPP-1 && pix_cnt==out_pixels-1). tlast accepted elsewhere -> err_early_last=1, word_idx and pix_cnt reset to 0. Expected end accepted without tlast -> err_missing_last=1, hold_last forced to 1 (row still terminated), counters wrap to 0. Both errors sticky until next accepted start.

## Timing
- Reset: all outputs 0, state IDLE, hold_v=0, counters 0.
- Latency: input accept edge -> m_axis_tvalid next cycle.
- Sustained throughput: 1 input word per 2 cycles, 1 output beat per cycle with m_axis_tready=1; no bubble between words.
- m_axis_tdata/tchan/tlast stable while tvalid && !tready.
- row_done and job_done registered, asserted the cycle after the final tlast handshake.
- Reset mid-job: data discarded, returns to IDLE, no pulses.

## Configuration
- CONV_ACC_UNPACK_CHECK_EN defined: pix_cnt and framing checks as above.
- Undefined: pix_cnt omitted; err_early_last and err_missing_last tied 0; tlast passed through unchanged; word_idx still resets to 0 on every accepted tlast.

## Test plan
- NUM_PE=32, out_pixels=2, out_rows=1, 32 words 0x{2k+1}{2k}, tlast on word 31, m_axis_tready=1 -> 64 beats, tchan 0..31 twice, data matches, tlast on beat 64 only, row_done then job_done, busy falls.
- Same stimulus, m_axis_tready toggling 1/0 -> identical beat sequence, data held stable during stalls, s_axis_tready never high while hold_v with low half pending.
- out_rows=3, one pixel per row -> three row_done pulses, one job_done after third, state IDLE; further tvalid sees tready=0.
- Check on: tlast on word 7 of pixel 0 -> err_early_last=1, next word gets tchan 0/1; err_missing_last stays 0.
- Check on: out_pixels=1, no tlast on word 15 -> err_missing_last=1, m_axis_tlast on beat 32, row_done pulse.
- aresetn asserted mid-row after 5 words -> all outputs 0; new start completes a clean row with no errors.

Source files
------------

// File: rtl/conv_acc_out_unpack_if.sv
// Stream bundle around the packed-result unpacker.
// s_axis_*: 32-bit words of two int16 channel results, received from the accelerator.
// m_axis_*: one 16-bit channel result per beat, tagged with its channel index.
// slave : the view the unpacker uses (consumes s_axis_*, produces m_axis_*).
// master: the view the surrounding environment uses.
interface conv_acc_out_unpack_if #(
   parameter int NUM_PE = 32
);
   localparam int CHAN_W = $clog2(NUM_PE);

   logic [31:0]       s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              s_axis_tready;

   logic [15:0]       m_axis_tdata;
   logic [CHAN_W-1:0] m_axis_tchan;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tchan, m_axis_tvalid, m_axis_tlast,
      input  m_axis_tready
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tchan, m_axis_tvalid, m_axis_tlast,
      output m_axis_tready
   );
endinterface

// File: rtl/conv_acc_out_unpack.sv
// Unpacks 32-bit accelerator result words (two int16 channels, low half first)
// into a 16-bit per-channel stream tagged with a channel index, counts output
// rows against the configured job geometry and returns to idle after the last row.
// Optional framing checker: define CONV_ACC_UNPACK_CHECK_EN to track the pixel
// position and flag early/missing input tlast. NUM_PE must be even and >= 4.
module conv_acc_out_unpack #(
   parameter int NUM_PE    = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   conv_acc_out_unpack_if.slave axis,
   input  logic [CNT_WIDTH-1:0] out_pixels,
   input  logic [CNT_WIDTH-1:0] out_rows,
   input  logic                 start,
   output logic                 busy,
   output logic                 row_done,
   output logic                 job_done,
   output logic                 err_early_last,
   output logic                 err_missing_last
);
   localparam int WPP    = NUM_PE / 2;
   localparam int CHAN_W = $clog2(NUM_PE);
   localparam int IDX_W  = CHAN_W - 1;
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(WPP - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t               state_q;
   logic [31:0]          hold_data_q;
   logic                 hold_v_q;
   logic                 hold_half_q;
   logic                 hold_last_q;
   logic [IDX_W-1:0]     chan_idx_q;   // word index of the word in the holding register
   logic [IDX_W-1:0]     word_idx_q;   // word index the next accepted word will get
   logic [CNT_WIDTH-1:0] rows_q;
   logic [CNT_WIDTH-1:0] row_cnt_q;
   logic                 row_done_q;
   logic                 job_done_q;

   logic                 s_ready;
   logic                 s_acc;
   logic                 m_hs;
   logic                 row_end;
   logic                 job_end;
   logic                 idx_wrap;
   logic                 hold_last_d;
   logic [IDX_W-1:0]     word_idx_d;

`ifdef CONV_ACC_UNPACK_CHECK_EN
   logic [CNT_WIDTH-1:0] pixels_q;
   logic [CNT_WIDTH-1:0] pix_cnt_q;
   logic [CNT_WIDTH-1:0] pix_cnt_d;
   logic                 err_early_q;
   logic                 err_missing_q;
   logic                 exp_end;
   logic                 early_d;
   logic                 missing_d;
`endif

   // A new word may enter when the register is empty or its high half leaves this cycle.
   assign s_ready  = (state_q == S_RUN) && (!hold_v_q || (hold_half_q && axis.m_axis_tready));
   assign s_acc    = axis.s_axis_tvalid && s_ready;
   assign m_hs     = hold_v_q && axis.m_axis_tready;
   assign row_end  = m_hs && hold_half_q && hold_last_q;
   assign job_end  = row_end && ((row_cnt_q + CNT_ONE) == rows_q);
   assign idx_wrap = (word_idx_q == IDX_LAST);

   // Framing decisions for the word presented on the input this cycle.
   always_comb begin
      // NOTE: every variable below is assigned on every path through this block,
      // so no latch can be inferred.
`ifdef CONV_ACC_UNPACK_CHECK_EN
      exp_end     = idx_wrap && (pix_cnt_q == (pixels_q - CNT_ONE));
      early_d     = axis.s_axis_tlast && !exp_end;
      missing_d   = exp_end && !axis.s_axis_tlast;
      hold_last_d = axis.s_axis_tlast || exp_end;
      pix_cnt_d   = hold_last_d ? '0 : (idx_wrap ? pix_cnt_q + CNT_ONE : pix_cnt_q);
`else
      hold_last_d = axis.s_axis_tlast;
`endif
      word_idx_d  = (hold_last_d || idx_wrap) ? '0 : word_idx_q + IDX_ONE;
   end

   assign axis.s_axis_tready = s_ready;
   assign axis.m_axis_tvalid = hold_v_q;
   assign axis.m_axis_tdata  = hold_half_q ? hold_data_q[31:16] : hold_data_q[15:0];
   assign axis.m_axis_tchan  = {chan_idx_q, hold_half_q};
   assign axis.m_axis_tlast  = hold_v_q && hold_half_q && hold_last_q;

   assign busy     = (state_q == S_RUN);
   assign row_done = row_done_q;
   assign job_done = job_done_q;
`ifdef CONV_ACC_UNPACK_CHECK_EN
   assign err_early_last   = err_early_q;
   assign err_missing_last = err_missing_q;
`else
   assign err_early_last   = 1'b0;
   assign err_missing_last = 1'b0;
`endif

   // Job FSM, holding register, counters and registered status pulses.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= S_IDLE;
         // NOTE: the holding register drives m_axis_tdata directly, so it is reset
         // too; that keeps every output at 0 while in reset.
         hold_data_q <= '0;
         hold_v_q    <= 1'b0;
         hold_half_q <= 1'b0;
         hold_last_q <= 1'b0;
         chan_idx_q  <= '0;
         word_idx_q  <= '0;
         rows_q      <= '0;
         row_cnt_q   <= '0;
         row_done_q  <= 1'b0;
         job_done_q  <= 1'b0;
`ifdef CONV_ACC_UNPACK_CHECK_EN
         pixels_q      <= '0;
         pix_cnt_q     <= '0;
         err_early_q   <= 1'b0;
         err_missing_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every right-hand side sees
         // the pre-edge value and later assignments override earlier ones.
         row_done_q <= 1'b0;
         job_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && (out_pixels != '0) && (out_rows != '0)) begin
                  state_q    <= S_RUN;
                  rows_q     <= out_rows;
                  row_cnt_q  <= '0;
                  word_idx_q <= '0;
`ifdef CONV_ACC_UNPACK_CHECK_EN
                  pixels_q      <= out_pixels;
                  pix_cnt_q     <= '0;
                  err_early_q   <= 1'b0;
                  err_missing_q <= 1'b0;
`endif
               end
            end
            S_RUN: begin
               if (s_acc) begin
                  hold_data_q <= axis.s_axis_tdata;
                  hold_v_q    <= 1'b1;
                  hold_half_q <= 1'b0;
                  hold_last_q <= hold_last_d;
                  chan_idx_q  <= word_idx_q;
                  word_idx_q  <= word_idx_d;
`ifdef CONV_ACC_UNPACK_CHECK_EN
                  pix_cnt_q <= pix_cnt_d;
                  if (early_d)   err_early_q   <= 1'b1;
                  if (missing_d) err_missing_q <= 1'b1;
`endif
               end else if (m_hs) begin
                  if (!hold_half_q) hold_half_q <= 1'b1;
                  else              hold_v_q    <= 1'b0;
               end
               if (row_end) begin
                  row_done_q <= 1'b1;
                  if (job_end) begin
                     job_done_q <= 1'b1;
                     state_q    <= S_IDLE;
                     row_cnt_q  <= '0;
                     hold_v_q   <= 1'b0;
                  end else begin
                     row_cnt_q <= row_cnt_q + CNT_ONE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule
